fetch_pc_ifid: RTL and testbench

Sequential back end of the fetch stage. Holds the program counter that drives `pc_in` into the fetch stage and loads it from the fetch stage's next-PC result (`pc_updated`) under `pc_write`. Captures the fetched instruction (`IR`, its PC and `pc_2`) into the IF/ID pipeline register with a valid bit. Handles boot hold-off, freeze (stall) and branch-redirect flush, and keeps fetch and bubble performance counters.

---
 rtl/fetch_pc_ifid.sv | 88 ++++++++
 tb/tb_fetch_pc_ifid.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fetch_pc_ifid.sv
// Fetch stage back end: program counter register, IF/ID pipeline register,
// boot hold-off, freeze, branch-redirect squash and fetch/bubble counters.
// All outputs are registered; no input reaches an output combinationally.
module fetch_pc_ifid #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned BOOT_CYCLES = 2          // 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_updated,
  input  logic        pc_write,
  input  logic [15:0] IR,
  input  logic [15:0] pc_2,
  input  logic        br_taken,
  output logic [15:0] pc_in,
  output logic [15:0] id_ir,
  output logic [15:0] id_pc,
  output logic [15:0] id_pc_2,
  output logic        id_valid,
  output logic [15:0] fetch_count,
  output logic [15:0] bubble_count
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  state_t     state, state_d;
  logic [3:0] boot_cnt, boot_cnt_d;
  logic       flush, advance;

  // Next-state logic: count out the boot window, then stay in RUN until reset.
  // In RUN a redirect wins over pc_write; BOOT ignores both.
  always_comb begin
    state_d    = state;
    boot_cnt_d = boot_cnt;
    flush      = 1'b0;
    advance    = 1'b0;
    case (state)
      BOOT: begin
        boot_cnt_d = boot_cnt + 4'd1;
        if (boot_cnt == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        flush   = br_taken;
        advance = !br_taken && pc_write;
      end
      default: state_d = BOOT;
    endcase
  end

  // State, PC, IF/ID and counters. Reset overrides everything; a frozen
  // RUN cycle (no flush, no advance) simply holds every register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      boot_cnt     <= 4'd0;
      pc_in        <= RESET_PC;
      id_ir        <= 16'h0000;
      id_pc        <= 16'h0000;
      id_pc_2      <= 16'h0000;
      id_valid     <= 1'b0;
      fetch_count  <= 16'h0000;
      bubble_count <= 16'h0000;
    end else begin
      state    <= state_d;
      boot_cnt <= boot_cnt_d;
      if (flush) begin
        // Squash the instruction in IF; the older one in IF/ID is
        // handled downstream by the ID/EX flush.
        pc_in        <= pc_updated;
        id_ir        <= 16'h0000;
        id_pc        <= 16'h0000;
        id_pc_2      <= 16'h0000;
        id_valid     <= 1'b0;
        bubble_count <= bubble_count + 16'd1;
      end else if (advance) begin
        pc_in       <= pc_updated;
        id_ir       <= IR;
        id_pc       <= pc_in;
        id_pc_2     <= pc_2;
        id_valid    <= 1'b1;
        fetch_count <= fetch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_ifid.sv
// Scoreboard bench for fetch_pc_ifid: stimulus pushes the hand-computed
// post-edge state, a monitor pops and compares just after each edge.
module tb_fetch_pc_ifid;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc_updated = '0;
  logic        pc_write = 1'b0;
  logic [15:0] IR = '0;
  logic [15:0] pc_2 = '0;
  logic        br_taken = 1'b0;
  logic [15:0] pc_in, id_ir, id_pc, id_pc_2, fetch_count, bubble_count;
  logic        id_valid;

  fetch_pc_ifid dut (
    .clk(clk), .rst(rst), .pc_updated(pc_updated), .pc_write(pc_write),
    .IR(IR), .pc_2(pc_2), .br_taken(br_taken), .pc_in(pc_in),
    .id_ir(id_ir), .id_pc(id_pc), .id_pc_2(id_pc_2), .id_valid(id_valid),
    .fetch_count(fetch_count), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [15:0] pc, ir, ipc, ipc2;
    logic        v;
    logic [15:0] fc, bc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  // Drive one cycle of inputs at the falling edge; optionally queue the
  // state expected right after the following rising edge.
  task automatic step(input string nm, input logic r, pw, br,
                      input logic [15:0] pu, ir, p2, input bit chk,
                      input logic [15:0] e_pc, e_ir, e_ipc, e_ipc2,
                      input logic e_v, input logic [15:0] e_fc, e_bc);
    exp_t e;
    @(negedge clk);
    rst = r; pc_write = pw; br_taken = br;
    pc_updated = pu; IR = ir; pc_2 = p2;
    if (chk) begin
      e.nm = nm; e.pc = e_pc; e.ir = e_ir; e.ipc = e_ipc; e.ipc2 = e_ipc2;
      e.v = e_v; e.fc = e_fc; e.bc = e_bc;
      q.push_back(e);
    end
  endtask

  // Monitor: compare the registered outputs against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (pc_in === e.pc && id_ir === e.ir && id_pc === e.ipc &&
            id_pc_2 === e.ipc2 && id_valid === e.v &&
            fetch_count === e.fc && bubble_count === e.bc)
          passed++;
        else
          $display("FAIL %s: got pc=%h ir=%h ipc=%h ipc2=%h v=%b fc=%h bc=%h, want pc=%h ir=%h ipc=%h ipc2=%h v=%b fc=%h bc=%h",
                   e.nm, pc_in, id_ir, id_pc, id_pc_2, id_valid, fetch_count, bubble_count,
                   e.pc, e.ir, e.ipc, e.ipc2, e.v, e.fc, e.bc);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //    name         rst pw br  pc_upd    IR        pc_2     chk pc        ir        ipc       ipc2      v     fc        bc
    step("reset_a",    1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step("reset_b",    1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step("boot_e1",    0, 1, 0, 16'h0002, 16'h1000, 16'h0002, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step("boot_br",    0, 1, 1, 16'h0040, 16'h1000, 16'h0002, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step("first_cap",  0, 1, 0, 16'h0002, 16'h1000, 16'h0002, 1, 16'h0002, 16'h1000, 16'h0000, 16'h0002, 1'b1, 16'h0001, 16'h0000);
    step("seq_1001",   0, 1, 0, 16'h0004, 16'h1001, 16'h0004, 1, 16'h0004, 16'h1001, 16'h0002, 16'h0004, 1'b1, 16'h0002, 16'h0000);
    step("seq_1002",   0, 1, 0, 16'h0006, 16'h1002, 16'h0006, 1, 16'h0006, 16'h1002, 16'h0004, 16'h0006, 1'b1, 16'h0003, 16'h0000);
    step("freeze_1",   0, 0, 0, 16'h0008, 16'h1003, 16'h0008, 1, 16'h0006, 16'h1002, 16'h0004, 16'h0006, 1'b1, 16'h0003, 16'h0000);
    step("freeze_2",   0, 0, 0, 16'h0008, 16'h1003, 16'h0008, 1, 16'h0006, 16'h1002, 16'h0004, 16'h0006, 1'b1, 16'h0003, 16'h0000);
    step("freeze_3",   0, 0, 0, 16'h0008, 16'h1003, 16'h0008, 1, 16'h0006, 16'h1002, 16'h0004, 16'h0006, 1'b1, 16'h0003, 16'h0000);
    step("seq_1003",   0, 1, 0, 16'h0008, 16'h1003, 16'h0008, 1, 16'h0008, 16'h1003, 16'h0006, 16'h0008, 1'b1, 16'h0004, 16'h0000);
    step("seq_1004",   0, 1, 0, 16'h000A, 16'h1004, 16'h000A, 1, 16'h000A, 16'h1004, 16'h0008, 16'h000A, 1'b1, 16'h0005, 16'h0000);
    step("br_frz",     0, 0, 1, 16'h0040, 16'h1005, 16'h000C, 1, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0005, 16'h0001);
    step("br_target",  0, 1, 0, 16'h0042, 16'h2000, 16'h0042, 1, 16'h0042, 16'h2000, 16'h0040, 16'h0042, 1'b1, 16'h0006, 16'h0001);
    step("br_adv",     0, 1, 1, 16'h0100, 16'h2001, 16'h0044, 1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0006, 16'h0002);
    step("bubble_frz", 0, 0, 0, 16'h0102, 16'h3000, 16'h0102, 1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0006, 16'h0002);
    step("br_target2", 0, 1, 0, 16'h0102, 16'h3000, 16'h0102, 1, 16'h0102, 16'h3000, 16'h0100, 16'h0102, 1'b1, 16'h0007, 16'h0002);
    step("mid_reset",  1, 1, 1, 16'h0200, 16'h4000, 16'h0104, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step("reboot_e1",  0, 1, 0, 16'h0002, 16'h1000, 16'h0002, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step("reboot_e2",  0, 1, 0, 16'h0002, 16'h1000, 16'h0002, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000);
    step("reboot_cap", 0, 1, 0, 16'h0002, 16'h1000, 16'h0002, 1, 16'h0002, 16'h1000, 16'h0000, 16'h0002, 1'b1, 16'h0001, 16'h0000);

    // Run fetch_count up to 16'hFFFF; only the last fetch of the run is checked.
    for (int k = 1; k <= 65534; k++) begin
      logic [15:0] pc_now;
      pc_now = 16'(2 * k);
      step("cnt_max", 0, 1, 0, pc_now + 16'd2, 16'(k), pc_now + 16'd2, (k == 65534),
           16'hFFFE, 16'hFFFE, 16'hFFFC, 16'hFFFE, 1'b1, 16'hFFFF, 16'h0000);
    end
    step("cnt_wrap",   0, 1, 0, 16'h0000, 16'hABCD, 16'h0000, 1, 16'h0000, 16'hABCD, 16'hFFFE, 16'h0000, 1'b1, 16'h0000, 16'h0000);

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
